// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP histogram block.
package lbp_pkg;
    localparam int IMG_W  = 7;
    localparam int CNT_W  = 14;
    localparam int ADDR_W = 2 * IMG_W;
    localparam int NBINS  = 256;

    localparam logic [IMG_W-1:0] BORDER_LO = '0;
    localparam logic [IMG_W-1:0] BORDER_HI = '1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/lbp_hist_if.sv
// Sample-in and bin-out streams between the LBP engine, the histogram and its consumer.
interface lbp_hist_if #(
    parameter int ADDR_W = lbp_pkg::ADDR_W,
    parameter int CNT_W  = lbp_pkg::CNT_W
);
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_last;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_last
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_last
    );
endinterface

// File: rtl/lbp_uniform_chk.sv
// Flags uniform LBP codes: at most two 0/1 transitions around the circular 8-bit pattern.
module lbp_uniform_chk
    import lbp_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       uniform_o
);
    logic [7:0] trans;
    logic [3:0] pop;

    always_comb begin
        trans = code_i ^ {code_i[6:0], code_i[7]};
        pop   = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + 4'(trans[i]);
        end
        uniform_o = (pop <= 4'd2);
    end
endmodule

// File: rtl/lbp_hist.sv
// 256-bin LBP code histogram with uniform/rejected tallies; drains bins over a valid/ready stream.
module lbp_hist #(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int CNT_W = lbp_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    lbp_hist_if.slave        io,
    input  logic             finish,
    input  logic             clear,
    output logic [CNT_W-1:0] uni_count,
    output logic [CNT_W-1:0] rej_count,
    output logic             done
);
    import lbp_pkg::*;

    state_e           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic             finish_q;
    logic [CNT_W-1:0] bins_q [NBINS];
    logic [CNT_W-1:0] uni_q, rej_q;
    logic [IMG_W-1:0] row, col;
    logic             border, uniform, acc_en, rise, clr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign row    = io.lbp_addr[2*IMG_W-1:IMG_W];
    assign col    = io.lbp_addr[IMG_W-1:0];
    assign border = (row == BORDER_LO) || (row == BORDER_HI) ||
                    (col == BORDER_LO) || (col == BORDER_HI);
    assign rise   = finish & ~finish_q;
    assign acc_en = (state_q == ACCUM) & io.lbp_valid;
    assign clr    = (state_q == DONE) & clear;

    lbp_uniform_chk u_uni (
        .code_i    (io.lbp_data),
        .uniform_o (uniform)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ACCUM: if (rise) state_d = DRAIN;
            DRAIN: begin
                if (io.hist_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'hFF) state_d = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = ACCUM;
                    idx_d   = 8'd0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // finish_q tracks the level in every state, so a level held across DONE never looks like a new rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ACCUM;
            idx_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            finish_q <= finish;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_q <= '0;
            rej_q <= '0;
        end else if (clr) begin
            uni_q <= '0;
            rej_q <= '0;
        end else if (acc_en) begin
            if (border) begin
                rej_q <= sat_inc(rej_q);
            end else if (uniform) begin
                uni_q <= sat_inc(uni_q);
            end
        end
    end

    // Single read-modify-write per cycle, so same-bin samples on consecutive edges never collide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
        end else if (acc_en && !border) begin
            bins_q[io.lbp_data] <= sat_inc(bins_q[io.lbp_data]);
        end
    end

    assign io.hist_valid = (state_q == DRAIN);
    assign io.hist_bin   = idx_q;
    assign io.hist_count = bins_q[idx_q];
    assign io.hist_last  = (state_q == DRAIN) && (idx_q == 8'hFF);
    assign uni_count     = uni_q;
    assign rej_count     = rej_q;
    assign done          = (state_q == DONE);
endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: full frame, border rejects, same-bin bursts, stalled drain, clear and reset abort.
module tb_lbp_hist;
    import lbp_pkg::*;

    logic             clk;
    logic             reset;
    logic             finish;
    logic             clear;
    logic [CNT_W-1:0] uni_count;
    logic [CNT_W-1:0] rej_count;
    logic             done;

    int n_checks;
    int n_errors;
    int exp_cnt [256];
    int exp_rej;
    int exp_uni;

    logic [13:0] t2_addr [15];
    bit          t2_bdr  [15];

    lbp_hist_if io ();

    lbp_hist dut (
        .clk       (clk),
        .reset     (reset),
        .io        (io.slave),
        .finish    (finish),
        .clear     (clear),
        .uni_count (uni_count),
        .rej_count (rej_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input logic [13:0] a, input logic [7:0] d);
        io.lbp_valid = 1'b1;
        io.lbp_addr  = a;
        io.lbp_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic zero_exp();
        for (int k = 0; k < 256; k++) exp_cnt[k] = 0;
    endtask

    task automatic start_drain();
        check("pre_drain_valid", 32'(io.hist_valid), 32'd0);
        finish = 1'b1;
        @(posedge clk); #1;
        io.lbp_valid = 1'b0;
        check("drain_latency", 32'(io.hist_valid), 32'd1);
        check("drain_first_bin", 32'(io.hist_bin), 32'd0);
    endtask

    // abort_at >= 0 returns with that bin presented but not yet handed over
    task automatic drain(input bit rnd, input bit poke, input int abort_at);
        int k, cyc;
        bit stalled;
        logic [7:0]       s_bin;
        logic [CNT_W-1:0] s_cnt;
        logic             s_last;
        k = 0; cyc = 0; stalled = 1'b0;
        s_bin = '0; s_cnt = '0; s_last = 1'b0;
        while (k < 256 && cyc < 2000) begin
            if (k == abort_at) begin
                io.hist_ready = 1'b0;
                io.lbp_valid  = 1'b0;
                return;
            end
            if (stalled) begin
                check("stall_valid", 32'(io.hist_valid), 32'd1);
                check("stall_bin", 32'(io.hist_bin), 32'(s_bin));
                check("stall_count", 32'(io.hist_count), 32'(s_cnt));
                check("stall_last", 32'(io.hist_last), 32'(s_last));
            end
            if (k == 255) check("done_before_last", 32'(done), 32'd0);
            io.hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                io.lbp_valid = 1'($urandom_range(0, 1));
                io.lbp_addr  = ($urandom_range(0, 1) != 0) ? 14'd129 : 14'd0;
                io.lbp_data  = 8'h0F;
            end
            if (io.hist_valid && io.hist_ready) begin
                check("drain_bin", 32'(io.hist_bin), 32'(k));
                check("drain_count", 32'(io.hist_count), 32'(exp_cnt[k]));
                check("drain_last", 32'(io.hist_last), 32'(k == 255));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                s_bin  = io.hist_bin;
                s_cnt  = io.hist_count;
                s_last = io.hist_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        io.hist_ready = 1'b0;
        io.lbp_valid  = 1'b0;
        check("drain_handshakes", 32'(k), 32'd256);
        if (!rnd) check("drain_cycles", 32'(cyc), 32'd256);
        check("done_after_drain", 32'(done), 32'd1);
        check("valid_after_drain", 32'(io.hist_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        finish = 1'b0;
        clear  = 1'b0;
        io.lbp_valid  = 1'b0;
        io.lbp_addr   = '0;
        io.lbp_data   = '0;
        io.hist_ready = 1'b0;
        t2_addr = '{14'd0, 14'd129, 14'd127, 14'd16256, 14'd1000, 14'd16383, 14'd128,
                    14'd5000, 14'd255, 14'd5, 14'd16300, 14'd8000, 14'd640, 14'd767, 14'd16254};
        t2_bdr  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(io.hist_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_last", 32'(io.hist_last), 32'd0);
        check("rst_bin", 32'(io.hist_bin), 32'd0);
        check("rst_count", 32'(io.hist_count), 32'd0);
        check("rst_uni", 32'(uni_count), 32'd0);
        check("rst_rej", 32'(rej_count), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full interior frame, code = col
        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++)
                sample(14'(r * 128 + c), 8'(c));
        io.lbp_valid = 1'b0;
        check("t1_rej", 32'(rej_count), 32'd0);
        check("t1_uni", 32'(uni_count), 32'd3402);
        zero_exp();
        for (int k = 1; k <= 126; k++) exp_cnt[k] = 126;
        start_drain();
        drain(1'b0, 1'b0, -1);

        // finish still high: clear must not retrigger a drain
        pulse_clear();
        check("clr_done", 32'(done), 32'd0);
        check("clr_uni", 32'(uni_count), 32'd0);
        check("clr_rej", 32'(rej_count), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("no_retrigger", 32'(io.hist_valid), 32'd0);
        finish = 1'b0;
        @(posedge clk); #1;

        // Border rejects mixed with interior 0x0F; clear in ACCUM is ignored
        exp_rej = 0; exp_uni = 0;
        for (int i = 0; i < 14; i++) begin
            clear = (i == 7);
            sample(t2_addr[i], 8'h0F);
            if (t2_bdr[i]) exp_rej++; else exp_uni++;
            check("t2_rej_run", 32'(rej_count), 32'(exp_rej));
            check("t2_uni_run", 32'(uni_count), 32'(exp_uni));
        end
        clear = 1'b0;
        check("t2_no_early_drain", 32'(io.hist_valid), 32'd0);
        io.lbp_valid = 1'b1;
        io.lbp_addr  = t2_addr[14];
        io.lbp_data  = 8'h0F;
        start_drain();
        check("t2_rej", 32'(rej_count), 32'd10);
        check("t2_uni", 32'(uni_count), 32'd5);
        zero_exp();
        exp_cnt[8'h0F] = 5;
        drain(1'b1, 1'b1, -1);
        check("t2_rej_frozen", 32'(rej_count), 32'd10);
        check("t2_uni_frozen", 32'(uni_count), 32'd5);

        // Same-bin bursts
        finish = 1'b0;
        pulse_clear();
        for (int i = 0; i < 20; i++) sample(14'(300 + i), 8'h55);
        check("t3_uni_55", 32'(uni_count), 32'd0);
        sample(14'd400, 8'hFF);
        check("t3_uni_lat", 32'(uni_count), 32'd1);
        sample(14'd401, 8'hFF);
        sample(14'd402, 8'hFF);
        io.lbp_valid = 1'b0;
        check("t3_uni", 32'(uni_count), 32'd3);
        check("t3_rej", 32'(rej_count), 32'd0);
        zero_exp();
        exp_cnt[8'h55] = 20;
        exp_cnt[8'hFF] = 3;
        start_drain();
        drain(1'b0, 1'b0, -1);

        // Reset mid-drain at bin 100
        finish = 1'b0;
        pulse_clear();
        for (int i = 0; i < 4; i++) sample(14'(500 + i), 8'h10);
        io.lbp_valid = 1'b0;
        zero_exp();
        exp_cnt[8'h10] = 4;
        start_drain();
        drain(1'b0, 1'b0, 100);
        check("abort_bin", 32'(io.hist_bin), 32'd100);
        finish = 1'b0;
        reset  = 1'b0;
        #1;
        check("abort_valid", 32'(io.hist_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bin_rst", 32'(io.hist_bin), 32'd0);
        check("abort_count", 32'(io.hist_count), 32'd0);
        check("abort_uni", 32'(uni_count), 32'd0);
        check("abort_rej", 32'(rej_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        sample(14'd600, 8'h03);
        sample(14'd601, 8'h03);
        sample(14'd0, 8'h03);
        io.lbp_valid = 1'b0;
        check("t4_uni", 32'(uni_count), 32'd2);
        check("t4_rej", 32'(rej_count), 32'd1);
        zero_exp();
        exp_cnt[8'h03] = 2;
        start_drain();
        drain(1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
